// File: rtl/elevator_sim_ctrl.sv
// SCAN-scheduled elevator car core: floor requests in, tick-paced moves and door cycles out.
// Define ESTOP_EN to add the estop input, which freezes motion and reports IDLE while held.
module elevator_sim_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_TICKS = 30,
    parameter int DOOR_TICKS  = 60
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  tick,
    input  logic                  req_valid,
    input  logic [3:0]            req_floor,
`ifdef ESTOP_EN
    input  logic                  estop,
`endif
    output logic [7:0]            destination,
    output logic [1:0]            sim_state,
    output logic [NUM_FLOORS-1:0] pending_floors
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_UP    = 2'b01;
    localparam logic [1:0] S_DOWN  = 2'b10;
    localparam logic [1:0] S_DOORS = 2'b11;

    localparam int CMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] FT_LAST = CW'(FLOOR_TICKS - 1);
    localparam logic [CW-1:0] DT_LAST = CW'(DOOR_TICKS - 1);

    logic [1:0]            state_q, state_n;
    logic [3:0]            cur_q, cur_n;
    logic                  dir_q, dir_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic [NUM_FLOORS-1:0] pending_q, pend_n;
    logic                  decide;
    logic                  hold;

`ifdef ESTOP_EN
    assign hold = estop;
`else
    assign hold = 1'b0;
`endif

    assign pending_floors = pending_q;

    function automatic logic bit_at(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (int'(f) == i) r = v[i];
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    // Nearest pending floor ahead of the car; stationary states point at the car itself.
    function automatic logic [3:0] target_of(input logic [1:0] st,
                                             input logic [NUM_FLOORS-1:0] v,
                                             input logic [3:0] f);
        logic [3:0] t;
        logic       found;
        t     = f;
        found = 1'b0;
        if (st == S_UP) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!found && v[i] && i > int'(f)) begin
                    t     = 4'(i);
                    found = 1'b1;
                end
            end
        end else if (st == S_DOWN) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (v[i] && i < int'(f)) t = 4'(i);
            end
        end
        return t;
    endfunction

    always_comb begin
        pend_n  = pending_q;
        state_n = state_q;
        cur_n   = cur_q;
        dir_n   = dir_q;
        cnt_n   = cnt_q;
        decide  = 1'b0;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req_valid && int'(req_floor) == i &&
                !(state_q == S_DOORS && req_floor == cur_q)) pend_n[i] = 1'b1;
        end

        if (!hold) begin
            case (state_q)
                S_IDLE: decide = 1'b1;
                S_UP, S_DOWN: begin
                    if (tick) begin
                        if (cnt_q == FT_LAST) begin
                            cnt_n  = '0;
                            cur_n  = (state_q == S_UP) ? cur_q + 4'd1 : cur_q - 4'd1;
                            decide = 1'b1;
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (cnt_q == DT_LAST) begin
                            cnt_n  = '0;
                            decide = 1'b1;
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end
                end
            endcase

            // Serving the current floor also swallows a same-cycle request for it.
            if (decide) begin
                if (bit_at(pending_q, cur_n)) begin
                    state_n = S_DOORS;
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        if (int'(cur_n) == i) pend_n[i] = 1'b0;
                    end
                end else if (dir_q ? any_above(pending_q, cur_n) : any_below(pending_q, cur_n)) begin
                    state_n = dir_q ? S_UP : S_DOWN;
                end else if (dir_q ? any_below(pending_q, cur_n) : any_above(pending_q, cur_n)) begin
                    dir_n   = !dir_q;
                    state_n = dir_q ? S_DOWN : S_UP;
                end else begin
                    state_n = S_IDLE;
                end
                if (state_n != state_q) cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cur_q       <= 4'd0;
            dir_q       <= 1'b1;
            cnt_q       <= '0;
            pending_q   <= '0;
            destination <= 8'h00;
            sim_state   <= S_IDLE;
        end else begin
            state_q     <= state_n;
            cur_q       <= cur_n;
            dir_q       <= dir_n;
            cnt_q       <= cnt_n;
            pending_q   <= pend_n;
            destination <= {target_of(state_n, pend_n, cur_n), cur_n};
            sim_state   <= hold ? S_IDLE : state_n;
        end
    end

endmodule
